// File: rtl/branch_rs.sv
// branch_rs: collapsing reservation station for the branch/jump unit, oldest-ready select, registered issue.
// Optional build macro BRANCH_RS_WAKEUP_BYPASS_EN lets select see this cycle's CDB broadcast.
module branch_rs #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [6:0]       dispatch_op_code,
    input  logic [2:0]       dispatch_funct3,
    input  logic [31:0]      dispatch_pc,
    input  logic [31:0]      dispatch_imm,
    input  logic [TAG_W-1:0] dispatch_rob_tag,
    input  logic             dispatch_rs1_ready,
    input  logic             dispatch_rs2_ready,
    input  logic [TAG_W-1:0] dispatch_rs1_tag,
    input  logic [TAG_W-1:0] dispatch_rs2_tag,
    input  logic [31:0]      dispatch_rs1_value,
    input  logic [31:0]      dispatch_rs2_value,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic [6:0]       issue_op_code,
    output logic [2:0]       issue_funct3,
    output logic [31:0]      issue_a,
    output logic [31:0]      issue_b,
    output logic [31:0]      issue_pc,
    output logic [31:0]      issue_imm,
    output logic [TAG_W-1:0] issue_tag
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic [IDX_W-1:0] ix(input int unsigned i);
        return IDX_W'(i);
    endfunction

    logic [6:0]       e_op      [DEPTH];
    logic [2:0]       e_f3      [DEPTH];
    logic [31:0]      e_pc      [DEPTH];
    logic [31:0]      e_imm     [DEPTH];
    logic [TAG_W-1:0] e_tag     [DEPTH];
    logic             e_rs1_rdy [DEPTH];
    logic             e_rs2_rdy [DEPTH];
    logic [TAG_W-1:0] e_rs1_tag [DEPTH];
    logic [TAG_W-1:0] e_rs2_tag [DEPTH];
    logic [31:0]      e_rs1_val [DEPTH];
    logic [31:0]      e_rs2_val [DEPTH];
    logic [CNT_W-1:0] count;

    logic [6:0]       n_op      [DEPTH];
    logic [2:0]       n_f3      [DEPTH];
    logic [31:0]      n_pc      [DEPTH];
    logic [31:0]      n_imm     [DEPTH];
    logic [TAG_W-1:0] n_tag     [DEPTH];
    logic             n_rs1_rdy [DEPTH];
    logic             n_rs2_rdy [DEPTH];
    logic [TAG_W-1:0] n_rs1_tag [DEPTH];
    logic [TAG_W-1:0] n_rs2_tag [DEPTH];
    logic [31:0]      n_rs1_val [DEPTH];
    logic [31:0]      n_rs2_val [DEPTH];

    logic             entry_valid [DEPTH];
    logic             wk_rs1_rdy  [DEPTH];
    logic             wk_rs2_rdy  [DEPTH];
    logic [31:0]      wk_rs1_val  [DEPTH];
    logic [31:0]      wk_rs2_val  [DEPTH];
    logic             sel_rdy     [DEPTH];

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic             issue_load;
    logic             dispatch_fire;
    logic [CNT_W-1:0] count_post;
    logic             d_rs1_hit, d_rs2_hit;

    assign dispatch_ready = (count < CNT_W'(DEPTH));
    assign dispatch_fire  = dispatch_valid && dispatch_ready && !flush;

    // Each stored entry as it will look after this edge's CDB capture.
    always_comb begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            entry_valid[ix(i)] = (CNT_W'(i) < count);
            wk_rs1_rdy[ix(i)]  = e_rs1_rdy[ix(i)] || (cdb_valid && (cdb_tag == e_rs1_tag[ix(i)]));
            wk_rs2_rdy[ix(i)]  = e_rs2_rdy[ix(i)] || (cdb_valid && (cdb_tag == e_rs2_tag[ix(i)]));
            wk_rs1_val[ix(i)]  = e_rs1_rdy[ix(i)] ? e_rs1_val[ix(i)] :
                                 (wk_rs1_rdy[ix(i)] ? cdb_value : e_rs1_val[ix(i)]);
            wk_rs2_val[ix(i)]  = e_rs2_rdy[ix(i)] ? e_rs2_val[ix(i)] :
                                 (wk_rs2_rdy[ix(i)] ? cdb_value : e_rs2_val[ix(i)]);
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
            sel_rdy[ix(i)] = entry_valid[ix(i)] && wk_rs1_rdy[ix(i)] && wk_rs2_rdy[ix(i)];
`else
            sel_rdy[ix(i)] = entry_valid[ix(i)] && e_rs1_rdy[ix(i)] && e_rs2_rdy[ix(i)];
`endif
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!sel_found && sel_rdy[ix(i)]) begin
                sel_found = 1'b1;
                sel_idx   = ix(i);
            end
        end
    end

    assign issue_load = sel_found && (!issue_valid || issue_ready);
    assign count_post = count - CNT_W'(issue_load);
    assign d_rs1_hit  = cdb_valid && (cdb_tag == dispatch_rs1_tag);
    assign d_rs2_hit  = cdb_valid && (cdb_tag == dispatch_rs2_tag);

    // Collapse: slots at or above the removed entry take their upper neighbour;
    // the new micro-op then lands at the post-collapse occupancy.
    always_comb begin
        for (int unsigned j = 0; j < DEPTH; j++) begin
            int unsigned s;
            s = j;
            if (issue_load && (ix(j) >= sel_idx) && (j + 1 < DEPTH))
                s = j + 1;
            n_op[ix(j)]      = e_op[ix(s)];
            n_f3[ix(j)]      = e_f3[ix(s)];
            n_pc[ix(j)]      = e_pc[ix(s)];
            n_imm[ix(j)]     = e_imm[ix(s)];
            n_tag[ix(j)]     = e_tag[ix(s)];
            n_rs1_tag[ix(j)] = e_rs1_tag[ix(s)];
            n_rs2_tag[ix(j)] = e_rs2_tag[ix(s)];
            n_rs1_rdy[ix(j)] = wk_rs1_rdy[ix(s)];
            n_rs2_rdy[ix(j)] = wk_rs2_rdy[ix(s)];
            n_rs1_val[ix(j)] = wk_rs1_val[ix(s)];
            n_rs2_val[ix(j)] = wk_rs2_val[ix(s)];
            if (dispatch_fire && (CNT_W'(j) == count_post)) begin
                n_op[ix(j)]      = dispatch_op_code;
                n_f3[ix(j)]      = dispatch_funct3;
                n_pc[ix(j)]      = dispatch_pc;
                n_imm[ix(j)]     = dispatch_imm;
                n_tag[ix(j)]     = dispatch_rob_tag;
                n_rs1_tag[ix(j)] = dispatch_rs1_tag;
                n_rs2_tag[ix(j)] = dispatch_rs2_tag;
                n_rs1_rdy[ix(j)] = dispatch_rs1_ready || d_rs1_hit;
                n_rs2_rdy[ix(j)] = dispatch_rs2_ready || d_rs2_hit;
                n_rs1_val[ix(j)] = (!dispatch_rs1_ready && d_rs1_hit) ? cdb_value : dispatch_rs1_value;
                n_rs2_val[ix(j)] = (!dispatch_rs2_ready && d_rs2_hit) ? cdb_value : dispatch_rs2_value;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_op[ix(i)]      <= '0;
                e_f3[ix(i)]      <= '0;
                e_pc[ix(i)]      <= '0;
                e_imm[ix(i)]     <= '0;
                e_tag[ix(i)]     <= '0;
                e_rs1_rdy[ix(i)] <= 1'b0;
                e_rs2_rdy[ix(i)] <= 1'b0;
                e_rs1_tag[ix(i)] <= '0;
                e_rs2_tag[ix(i)] <= '0;
                e_rs1_val[ix(i)] <= '0;
                e_rs2_val[ix(i)] <= '0;
            end
        end else begin
            count <= flush ? '0 : (count_post + CNT_W'(dispatch_fire));
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_op[ix(i)]      <= n_op[ix(i)];
                e_f3[ix(i)]      <= n_f3[ix(i)];
                e_pc[ix(i)]      <= n_pc[ix(i)];
                e_imm[ix(i)]     <= n_imm[ix(i)];
                e_tag[ix(i)]     <= n_tag[ix(i)];
                e_rs1_rdy[ix(i)] <= n_rs1_rdy[ix(i)];
                e_rs2_rdy[ix(i)] <= n_rs2_rdy[ix(i)];
                e_rs1_tag[ix(i)] <= n_rs1_tag[ix(i)];
                e_rs2_tag[ix(i)] <= n_rs2_tag[ix(i)];
                e_rs1_val[ix(i)] <= n_rs1_val[ix(i)];
                e_rs2_val[ix(i)] <= n_rs2_val[ix(i)];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid   <= 1'b0;
            issue_op_code <= '0;
            issue_funct3  <= '0;
            issue_a       <= '0;
            issue_b       <= '0;
            issue_pc      <= '0;
            issue_imm     <= '0;
            issue_tag     <= '0;
        end else if (flush) begin
            issue_valid <= 1'b0;
        end else if (issue_load) begin
            issue_valid   <= 1'b1;
            issue_op_code <= e_op[sel_idx];
            issue_funct3  <= e_f3[sel_idx];
            issue_a       <= wk_rs1_val[sel_idx];
            issue_b       <= wk_rs2_val[sel_idx];
            issue_pc      <= e_pc[sel_idx];
            issue_imm     <= e_imm[sel_idx];
            issue_tag     <= e_tag[sel_idx];
        end else if (issue_ready) begin
            issue_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Scoreboard bench for branch_rs: queue-based reference model predicts issue order, timing and occupancy.
module tb_branch_rs;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam logic [6:0] OP_BR   = 7'h63;
    localparam logic [6:0] OP_JAL  = 7'h6F;
    localparam logic [6:0] OP_JALR = 7'h67;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             flush = 1'b0;
    logic             dispatch_valid = 1'b0;
    logic             dispatch_ready;
    logic [6:0]       dispatch_op_code = '0;
    logic [2:0]       dispatch_funct3 = '0;
    logic [31:0]      dispatch_pc = '0;
    logic [31:0]      dispatch_imm = '0;
    logic [TAG_W-1:0] dispatch_rob_tag = '0;
    logic             dispatch_rs1_ready = 1'b0;
    logic             dispatch_rs2_ready = 1'b0;
    logic [TAG_W-1:0] dispatch_rs1_tag = '0;
    logic [TAG_W-1:0] dispatch_rs2_tag = '0;
    logic [31:0]      dispatch_rs1_value = '0;
    logic [31:0]      dispatch_rs2_value = '0;
    logic             cdb_valid = 1'b0;
    logic [TAG_W-1:0] cdb_tag = '0;
    logic [31:0]      cdb_value = '0;
    logic             issue_valid;
    logic             issue_ready = 1'b1;
    logic [6:0]       issue_op_code;
    logic [2:0]       issue_funct3;
    logic [31:0]      issue_a, issue_b, issue_pc, issue_imm;
    logic [TAG_W-1:0] issue_tag;

    branch_rs #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_op_code(dispatch_op_code), .dispatch_funct3(dispatch_funct3),
        .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
        .dispatch_rob_tag(dispatch_rob_tag),
        .dispatch_rs1_ready(dispatch_rs1_ready), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs2_tag(dispatch_rs2_tag),
        .dispatch_rs1_value(dispatch_rs1_value), .dispatch_rs2_value(dispatch_rs2_value),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op_code(issue_op_code), .issue_funct3(issue_funct3),
        .issue_a(issue_a), .issue_b(issue_b), .issue_pc(issue_pc),
        .issue_imm(issue_imm), .issue_tag(issue_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]       op;
        logic [2:0]       f3;
        logic [31:0]      pc, imm;
        logic [TAG_W-1:0] tag;
        logic             r1, r2;
        logic [TAG_W-1:0] t1, t2;
        logic [31:0]      v1, v2;
    } ent_t;

    typedef struct packed {
        logic [6:0]       op;
        logic [2:0]       f3;
        logic [31:0]      a, b, pc, imm;
        logic [TAG_W-1:0] tag;
    } iss_t;

    ent_t mq[$];
    iss_t exp_q[$];
    bit   m_iv = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [TAG_W-1:0] t);
        return cdb_valid && (cdb_tag == t);
    endfunction

    function automatic bit can_issue(input ent_t e);
`ifdef BRANCH_RS_WAKEUP_BYPASS_EN
        return (e.r1 || hit(e.t1)) && (e.r2 || hit(e.t2));
`else
        return e.r1 && e.r2;
`endif
    endfunction

    // One clock edge of the station as a queue: oldest ready leaves, CDB wakes, dispatch appends.
    function automatic void model_edge();
        bit   had_room = (mq.size() < DEPTH);
        int   pick = -1;
        ent_t e;
        iss_t x;
        for (int i = 0; i < mq.size(); i++)
            if (pick < 0 && can_issue(mq[i])) pick = i;
        if (pick >= 0 && (!m_iv || issue_ready)) begin
            e = mq[pick];
            x.op = e.op; x.f3 = e.f3; x.pc = e.pc; x.imm = e.imm; x.tag = e.tag;
            x.a = (!e.r1 && hit(e.t1)) ? cdb_value : e.v1;
            x.b = (!e.r2 && hit(e.t2)) ? cdb_value : e.v2;
            exp_q.push_back(x);
            mq.delete(pick);
            m_iv = 1'b1;
        end else if (issue_ready) begin
            m_iv = 1'b0;
        end
        for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].r1 && hit(mq[i].t1)) begin mq[i].r1 = 1'b1; mq[i].v1 = cdb_value; end
            if (!mq[i].r2 && hit(mq[i].t2)) begin mq[i].r2 = 1'b1; mq[i].v2 = cdb_value; end
        end
        if (dispatch_valid && had_room) begin
            e.op = dispatch_op_code; e.f3 = dispatch_funct3; e.pc = dispatch_pc;
            e.imm = dispatch_imm; e.tag = dispatch_rob_tag;
            e.t1 = dispatch_rs1_tag; e.t2 = dispatch_rs2_tag;
            e.r1 = dispatch_rs1_ready || hit(dispatch_rs1_tag);
            e.r2 = dispatch_rs2_ready || hit(dispatch_rs2_tag);
            e.v1 = (!dispatch_rs1_ready && hit(dispatch_rs1_tag)) ? cdb_value : dispatch_rs1_value;
            e.v2 = (!dispatch_rs2_ready && hit(dispatch_rs2_tag)) ? cdb_value : dispatch_rs2_value;
            mq.push_back(e);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst || flush) begin
                mq.delete();
                exp_q.delete();
                m_iv = 1'b0;
            end else begin
                model_edge();
            end
        end
    end

    // Monitor: every negedge compare status, and pop/compare on each accepted issue.
    initial begin
        iss_t act, prev;
        bit   prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            act = {issue_op_code, issue_funct3, issue_a, issue_b, issue_pc, issue_imm, issue_tag};
            check("issue_valid", issue_valid, m_iv);
            check("dispatch_ready", dispatch_ready, mq.size() < DEPTH);
            if (prev_stall && issue_valid) check("stall_hold", act, prev);
            if (issue_valid && issue_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL issue_unexpected: got %0h expected none at %0t", act, $time);
                end else begin
                    check("issue_payload", act, exp_q.pop_front());
                end
            end
            prev_stall = issue_valid && !issue_ready;
            prev = act;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        dispatch_valid = 1'b0;
        cdb_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic set_disp(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                            input logic [31:0] imm, input logic [TAG_W-1:0] tag,
                            input logic r1, input logic [TAG_W-1:0] t1, input logic [31:0] v1,
                            input logic r2, input logic [TAG_W-1:0] t2, input logic [31:0] v2);
        dispatch_valid = 1'b1;
        dispatch_op_code = op; dispatch_funct3 = f3; dispatch_pc = pc;
        dispatch_imm = imm; dispatch_rob_tag = tag;
        dispatch_rs1_ready = r1; dispatch_rs1_tag = t1; dispatch_rs1_value = v1;
        dispatch_rs2_ready = r2; dispatch_rs2_tag = t2; dispatch_rs2_value = v2;
    endtask

    task automatic set_cdb(input logic [TAG_W-1:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag = t;
        cdb_value = v;
    endtask

    task automatic check_reset_outputs();
        check("rst_issue_valid", issue_valid, 1'b0);
        check("rst_dispatch_ready", dispatch_ready, 1'b1);
        check("rst_payload", {issue_op_code, issue_funct3, issue_a, issue_b, issue_pc, issue_imm, issue_tag}, '0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        tick();

        // Ready beq: a=b=5, pc 0x100, imm 0x10, tag 3.
        set_disp(OP_BR, 3'd0, 32'h100, 32'h10, 4'd3, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd5);
        repeat (4) tick();

        // A waits on tag 7, B ready; B goes first, then A with a=0x42.
        set_disp(OP_BR, 3'd1, 32'h200, 32'h8, 4'd1, 1'b0, 4'd7, 32'd0, 1'b1, 4'd0, 32'd9);
        tick();
        set_disp(OP_JAL, 3'd0, 32'h204, 32'h40, 4'd2, 1'b1, 4'd0, 32'd0, 1'b1, 4'd0, 32'd0);
        repeat (3) tick();
        set_cdb(4'd7, 32'h42);
        repeat (4) tick();

        // Dispatch-time capture of rs2 from the CDB.
        set_disp(OP_BR, 3'd4, 32'h300, 32'h4, 4'd5, 1'b1, 4'd0, 32'd1, 1'b0, 4'd9, 32'd0);
        set_cdb(4'd9, 32'hDEAD);
        repeat (4) tick();

        // Full and stall.
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            set_disp(OP_JALR, 3'd0, 32'h400 + 32'(4 * i), 32'(i), 4'(8 + i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'd0);
            tick();
        end
        repeat (3) tick();
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        repeat (2) tick();
        issue_ready = 1'b1;
        repeat (DEPTH + 3) tick();

        // Flush with a dispatch in the same cycle.
        issue_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            set_disp(OP_BR, 3'd5, 32'h500 + 32'(4 * i), 32'd0, 4'(i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'(i));
            tick();
        end
        flush = 1'b1;
        set_disp(OP_BR, 3'd6, 32'h5F0, 32'd0, 4'd15, 1'b1, 4'd0, 32'd1, 1'b1, 4'd0, 32'd2);
        tick();
        issue_ready = 1'b1;
        repeat (4) tick();

        // Asynchronous reset in the middle of activity.
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_disp(OP_JAL, 3'd0, 32'h600 + 32'(4 * i), 32'd0, 4'(i), 1'b1, 4'd0, 32'hA, 1'b1, 4'd0, 32'hB);
            tick();
        end
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        @(posedge clk); #1 rst = 1'b0;
        issue_ready = 1'b1;
        tick();

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [6:0] op;
                logic r1, r2;
                case ($urandom_range(0, 2))
                    0: op = OP_BR;
                    1: op = OP_JAL;
                    default: op = OP_JALR;
                endcase
                r1 = (op == OP_JAL) || ($urandom_range(0, 2) != 0);
                r2 = (op != OP_BR) || ($urandom_range(0, 2) != 0);
                set_disp(op, 3'($urandom), $urandom, $urandom, 4'($urandom),
                         r1, 4'($urandom), $urandom, r2, 4'($urandom), $urandom);
            end
            if ($urandom_range(0, 1) == 1) set_cdb(4'($urandom), $urandom);
            issue_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 63) == 0);
            tick();
        end

        // Drain: wake every tag and let everything issue.
        issue_ready = 1'b1;
        for (int t = 0; t < 16; t++) begin
            set_cdb(4'(t), $urandom);
            tick();
        end
        repeat (DEPTH + 4) tick();
        check("drain_issue_valid", issue_valid, 1'b0);
        check("drain_dispatch_ready", dispatch_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
